// File: rtl/dnn_result_collector.sv
// Pairs DNN out0/out1 scores into class/margin results and queues them in an FWFT FIFO.
// Latency: result visible 1 cycle after the completing ready. Backpressure: res_ready; a full FIFO drops the new result and flags overflow.
module dnn_result_collector #(
    parameter int output_width = 17,
    parameter int fifo_depth   = 4,
    parameter int cnt_width    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              out0_ready,
    input  logic                              out1_ready,
    input  logic [output_width-1:0]           out0,
    input  logic [output_width-1:0]           out1,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic                              res_class,
    output logic [output_width:0]             res_margin,
    output logic [$clog2(fifo_depth):0]       fifo_level,
    output logic                              overflow,
    output logic                              pair_err,
    output logic [cnt_width-1:0]              result_cnt
);

    localparam int AW = $clog2(fifo_depth);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic                  cls;
        logic [output_width:0] mar;
    } res_t;

    logic                    hold0_v_q, hold0_v_d, hold1_v_q, hold1_v_d;
    logic [output_width-1:0] hold0_q, hold0_d, hold1_q, hold1_d;
    logic                    pair_err_q, pair_err_d;
    logic                    overflow_q, overflow_d;
    logic [cnt_width-1:0]    result_cnt_q, result_cnt_d;
    logic [LW-1:0]           count_q, count_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    res_t                    last_q, last_d;
    res_t                    mem [fifo_depth];

    logic                        complete, full, pop, push_ok;
    logic signed [output_width:0] s0, s1, diff;
    res_t                        new_res, head;

    // A pair completes when both scores are available at this edge, fresh or held.
    assign complete = (out0_ready && out1_ready) ||
                      (out0_ready && hold1_v_q)  ||
                      (out1_ready && hold0_v_q);

    assign s0   = out0_ready ? {out0[output_width-1], out0} : {hold0_q[output_width-1], hold0_q};
    assign s1   = out1_ready ? {out1[output_width-1], out1} : {hold1_q[output_width-1], hold1_q};
    assign diff = s0 - s1;

    assign new_res.cls = diff[output_width];
    assign new_res.mar = diff[output_width] ? $unsigned(-diff) : $unsigned(diff);

    assign res_valid = (count_q != '0);
    assign full      = (count_q == LW'(fifo_depth));
    assign pop       = res_valid && res_ready;
    assign push_ok   = complete && (!full || pop);

    assign head       = res_valid ? mem[rd_ptr_q] : last_q;
    assign res_class  = head.cls;
    assign res_margin = head.mar;
    assign fifo_level = count_q;
    assign overflow   = overflow_q;
    assign pair_err   = pair_err_q;
    assign result_cnt = result_cnt_q;

    always_comb begin
        hold0_v_d    = hold0_v_q;
        hold1_v_d    = hold1_v_q;
        hold0_d      = hold0_q;
        hold1_d      = hold1_q;
        pair_err_d   = pair_err_q;
        overflow_d   = overflow_q;
        result_cnt_d = result_cnt_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        last_d       = last_q;

        if (complete) begin
            hold0_v_d = 1'b0;
            hold1_v_d = 1'b0;
        end else begin
            if (out0_ready) begin
                pair_err_d = pair_err_q | hold0_v_q;
                hold0_v_d  = 1'b1;
                hold0_d    = out0;
            end
            if (out1_ready) begin
                pair_err_d = pair_err_d | hold1_v_q;
                hold1_v_d  = 1'b1;
                hold1_d    = out1;
            end
        end

        if (complete && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d     = wr_ptr_q + AW'(1);
            result_cnt_d = result_cnt_q + cnt_width'(1);
        end
        // Popped head is kept so the outputs hold their last value once empty.
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            last_d   = mem[rd_ptr_q];
        end
        if (push_ok && !pop) begin
            count_d = count_q + LW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold0_v_q    <= 1'b0;
            hold1_v_q    <= 1'b0;
            hold0_q      <= '0;
            hold1_q      <= '0;
            pair_err_q   <= 1'b0;
            overflow_q   <= 1'b0;
            result_cnt_q <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_q       <= '0;
        end else begin
            hold0_v_q    <= hold0_v_d;
            hold1_v_q    <= hold1_v_d;
            hold0_q      <= hold0_d;
            hold1_q      <= hold1_d;
            pair_err_q   <= pair_err_d;
            overflow_q   <= overflow_d;
            result_cnt_q <= result_cnt_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_q       <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= new_res;
        end
    end

endmodule

// File: tb/tb_dnn_result_collector.sv
// Randomized + directed bench for dnn_result_collector with a queue-based scoreboard.
module tb_dnn_result_collector;

    localparam int W     = 17;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          out0_ready = 1'b0, out1_ready = 1'b0;
    logic [W-1:0]  out0 = '0, out1 = '0;
    logic          res_valid, res_ready = 1'b0, res_class;
    logic [W:0]    res_margin;
    logic [2:0]    fifo_level;
    logic          overflow, pair_err;
    logic [15:0]   result_cnt;

    dnn_result_collector #(.output_width(W), .fifo_depth(DEPTH), .cnt_width(16)) dut (
        .clk(clk), .rst(rst),
        .out0_ready(out0_ready), .out1_ready(out1_ready),
        .out0(out0), .out1(out1),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_margin(res_margin),
        .fifo_level(fifo_level), .overflow(overflow), .pair_err(pair_err),
        .result_cnt(result_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int cls; int mar; } res_t;

    res_t exp_q[$];
    int   n_cmp = 0, n_bad = 0;
    int   m_level, m_cnt, m_ovf, m_perr, m_h0v, m_h1v, m_h0, m_h1;
    int   last_cls, last_mar;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_level = 0; m_cnt = 0; m_ovf = 0; m_perr = 0;
        m_h0v = 0; m_h1v = 0; m_h0 = 0; m_h1 = 0;
        last_cls = 0; last_mar = 0;
    endtask

    task automatic check_state();
        chk("fifo_level", int'(fifo_level), m_level);
        chk("res_valid",  int'(res_valid), (m_level > 0) ? 1 : 0);
        chk("overflow",   int'(overflow), m_ovf);
        chk("pair_err",   int'(pair_err), m_perr);
        chk("result_cnt", int'(result_cnt), m_cnt);
    endtask

    // One clock of stimulus; the model predicts what the coming edge does.
    task automatic cyc(input bit r0, input bit r1, input int v0, input int v1, input bit rdy);
        int   s0, s1, d;
        bit   comp, pop;
        res_t e;
        check_state();
        out0_ready = r0; out1_ready = r1;
        out0 = v0[W-1:0]; out1 = v1[W-1:0];
        res_ready = rdy;
        comp = (r0 && r1) || (r0 && m_h1v != 0) || (r1 && m_h0v != 0);
        pop  = (m_level > 0) && rdy;
        if (comp) begin
            s0 = r0 ? v0 : m_h0;
            s1 = r1 ? v1 : m_h1;
            m_h0v = 0; m_h1v = 0;
            if (m_level < DEPTH || pop) begin
                d = s0 - s1;
                e.cls = (s1 > s0) ? 1 : 0;
                e.mar = (d < 0) ? -d : d;
                exp_q.push_back(e);
                m_level++;
                m_cnt = (m_cnt + 1) % 65536;
            end else begin
                m_ovf = 1;
            end
        end else begin
            if (r0) begin if (m_h0v != 0) m_perr = 1; m_h0v = 1; m_h0 = v0; end
            if (r1) begin if (m_h1v != 0) m_perr = 1; m_h1v = 1; m_h1 = v1; end
        end
        if (pop) m_level--;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        out0_ready = 1'b0; out1_ready = 1'b0; res_ready = 1'b0;
        model_clear();
        @(posedge clk); #1;
        check_state();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("res_class",  int'(res_class),  exp_q[0].cls);
                    chk("res_margin", int'(res_margin), exp_q[0].mar);
                    if (res_ready) begin
                        last_cls = exp_q[0].cls;
                        last_mar = exp_q[0].mar;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("hold_class",  int'(res_class),  last_cls);
                chk("hold_margin", int'(res_margin), last_mar);
            end
        end
    end

    initial begin
        model_clear();
        #2;
        do_reset();
        idle(10, 1);

        cyc(1, 1, 100, -50, 0);
        idle(3, 1);

        cyc(0, 1, 0, 200, 1);
        idle(3, 1);
        cyc(1, 0, -65536, 0, 1);
        idle(2, 1);
        cyc(1, 1, 5, 5, 1);
        idle(2, 1);

        cyc(1, 0, 10, 0, 1);
        idle(1, 1);
        cyc(1, 0, 20, 0, 1);
        cyc(0, 1, 0, 5, 1);
        idle(2, 1);

        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 1, i * 7, -i, 0);
        cyc(1, 1, 1000, 3, 1);
        idle(1, 0);
        idle(6, 1);

        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 1, i * 10 - 20, 30 - i, 0);
        idle(2, 0);
        idle(6, 1);

        cyc(1, 0, 7, 0, 1);
        do_reset();
        cyc(0, 1, 0, 9, 1);
        idle(3, 1);

        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                    int'($urandom_range(0, 131071)) - 65536,
                    int'($urandom_range(0, 131071)) - 65536,
                    $urandom_range(0, 3) != 0);
            end
        end
        idle(8, 1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
